// File: rtl/i2s_apb_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// i2s_apb_sequencer_pkg
// Shared types and constants for the I2S APB sequencer:
//   OP_t        - transceiver control word (tran_en is bit 0)
//   seq_state_t - sequencer FSM state encoding
//   *_OFS       - register offsets inside the I2S_top window
//   STAT_*_BIT  - STATUS register bit positions
// Optional build macro used by the sequencer files: I2S_SEQ_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package i2s_apb_sequencer_pkg;

    typedef struct packed {
        logic [30:0] op_cfg;
        logic        tran_en;
    } OP_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_STAT,
        S_TXW,
        S_RXR,
        S_GAP,
        S_DIS,
        S_FIN
    } seq_state_t;

    localparam logic [31:0] CTRL_OFS = 32'h0000_0000;
    localparam logic [31:0] TX_OFS   = 32'h0000_0004;
    localparam logic [31:0] RX_OFS   = 32'h0000_0008;
    localparam logic [31:0] STAT_OFS = 32'h0000_000C;

    localparam int STAT_TXFULL_BIT  = 0;
    localparam int STAT_RXEMPTY_BIT = 1;

    // Control word as written to CTRL, with the enable bit overridden.
    function automatic logic [31:0] with_tran_en(input OP_t c, input logic en);
        OP_t r;
        r         = c;
        r.tran_en = en;
        return r;
    endfunction

endpackage

// File: rtl/i2s_apb_sequencer_apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if
// Single-transfer APB master. A one-cycle req while idle starts a SETUP
// cycle; ACCESS is held until pready. ack is high in the completion cycle
// and rdata is valid alongside it.
// Ports:
//   clk, srst                     clock, synchronous active-high reset
//   req, wr, addr, wdata          transfer request (sampled when idle)
//   psel, penable, pwrite,
//   paddr, pwdata, prdata, pready APB master signals
//   idle                          no transfer in flight
//   ack, rdata                    completion strobe and read data
//   timeout                       transfer abandoned (I2S_SEQ_TIMEOUT_EN only)
// Macro I2S_SEQ_TIMEOUT_EN: abandon an ACCESS phase after 255 cycles
// without pready; otherwise wait indefinitely and timeout stays 0.
// ---------------------------------------------------------------------------
module apb_master_if (
    input  logic        clk,
    input  logic        srst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    output logic        idle,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        timeout
);

    logic        psel_reg;
    logic        penable_reg;
    logic        pwrite_reg;
    logic [31:0] paddr_reg;
    logic [31:0] pwdata_reg;
    logic        access;

    assign access = psel_reg && penable_reg;

`ifdef I2S_SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;

    always_ff @(posedge clk) begin
        if (srst || !access || pready) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end

    // Counter reads 254 in the 255th ACCESS cycle without pready.
    assign timeout = access && !pready && (wait_cnt_reg == 8'd254);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
        end else if (!psel_reg) begin
            if (req) begin
                psel_reg    <= 1'b1;
                penable_reg <= 1'b0;
                pwrite_reg  <= wr;
                paddr_reg   <= addr;
                pwdata_reg  <= wdata;
            end
        end else if (!penable_reg) begin
            penable_reg <= 1'b1;
        end else if (pready || timeout) begin
            // Address/data are left in place; only the strobes drop.
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
        end
    end

    assign psel    = psel_reg;
    assign penable = penable_reg;
    assign pwrite  = pwrite_reg;
    assign paddr   = paddr_reg;
    assign pwdata  = pwdata_reg;
    assign idle    = !psel_reg;
    assign ack     = access && pready;
    assign rdata   = prdata;

endmodule

// File: rtl/i2s_apb_sequencer.sv
// ---------------------------------------------------------------------------
// i2s_apb_sequencer
// APB master that enables an I2S_top transceiver, streams tx_len words into
// its TX register, drains rx_len words from its RX register, then disables
// it. STATUS is polled before every data transfer; when both directions can
// be served they alternate, RX first after each start.
// Ports:
//   pclk, preset                  clock, synchronous active-high reset
//   start, abort                  start pulse (IDLE only), abort level
//   cfg, tx_len, rx_len           control word and word counts (at start)
//   tx_data, tx_valid, tx_ready   TX word stream in
//   rx_data, rx_valid             RX word stream out
//   psel .. pready                APB master port
//   busy, done, err               sequence status
// Macro I2S_SEQ_TIMEOUT_EN: APB transfers abandon after 255 stalled ACCESS
// cycles and err is set; otherwise err is tied to 0.
// ---------------------------------------------------------------------------
module i2s_apb_sequencer
    import i2s_apb_sequencer_pkg::*;
#(
    parameter logic [31:0] ADR_OFFSET = 32'h0,
    parameter int          CNT_W      = 16,
    parameter int          POLL_GAP   = 4
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg,
    input  logic [CNT_W-1:0] tx_len,
    input  logic [CNT_W-1:0] rx_len,
    input  logic [31:0]      tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [31:0]      rx_data,
    output logic             rx_valid,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [31:0]      paddr,
    output logic [31:0]      pwdata,
    input  logic [31:0]      prdata,
    input  logic             pready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    seq_state_t       state_reg, state_next;
    OP_t              cfg_reg;
    logic [CNT_W-1:0] tx_len_reg, rx_len_reg;
    logic [CNT_W-1:0] tx_sent_reg, rx_got_reg;
    logic             last_tx_reg;
    logic             abort_pend_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [31:0]      rx_data_reg;
    logic             rx_valid_reg;

    logic        m_req, m_wr, m_idle, m_ack, m_timeout;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic tx_elig, rx_elig, pick_tx, pick_rx, abort_now, all_done;

    apb_master_if u_apb (
        .clk     (pclk),
        .srst    (preset),
        .req     (m_req),
        .wr      (m_wr),
        .addr    (m_addr),
        .wdata   (m_wdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .idle    (m_idle),
        .ack     (m_ack),
        .rdata   (m_rdata),
        .timeout (m_timeout)
    );

    // Eligibility is only meaningful in the STATUS read completion cycle.
    assign tx_elig   = (tx_sent_reg < tx_len_reg) && tx_valid && !m_rdata[STAT_TXFULL_BIT];
    assign rx_elig   = (rx_got_reg < rx_len_reg) && !m_rdata[STAT_RXEMPTY_BIT];
    assign pick_tx   = tx_elig && (!rx_elig || !last_tx_reg);
    assign pick_rx   = rx_elig && !pick_tx;
    assign abort_now = abort || abort_pend_reg;
    assign all_done  = (tx_sent_reg == tx_len_reg) && (rx_got_reg == rx_len_reg);

    always_comb begin
        state_next = state_reg;
        m_req      = 1'b0;
        m_wr       = 1'b0;
        m_addr     = ADR_OFFSET + STAT_OFS;
        m_wdata    = '0;
        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = ((tx_len == '0) && (rx_len == '0)) ? S_DIS : S_CFG;
                end
            end
            S_CFG: begin
                m_req   = m_idle;
                m_wr    = 1'b1;
                m_addr  = ADR_OFFSET + CTRL_OFS;
                m_wdata = with_tran_en(cfg_reg, 1'b1);
                if (m_timeout) begin
                    state_next = S_DIS;
                end else if (m_ack) begin
                    state_next = abort_now ? S_DIS : S_STAT;
                end
            end
            S_STAT: begin
                // psel low here means the poll has not been issued yet,
                // so completion/abort is decided before touching the bus.
                if (m_idle) begin
                    if (abort_now || all_done) begin
                        state_next = S_DIS;
                    end else begin
                        m_req = 1'b1;
                    end
                end else if (m_timeout) begin
                    state_next = S_DIS;
                end else if (m_ack) begin
                    if (abort_now) begin
                        state_next = S_DIS;
                    end else if (pick_tx) begin
                        state_next = S_TXW;
                    end else if (pick_rx) begin
                        state_next = S_RXR;
                    end else begin
                        state_next = (POLL_GAP == 0) ? S_STAT : S_GAP;
                    end
                end
            end
            S_TXW: begin
                m_req   = m_idle;
                m_wr    = 1'b1;
                m_addr  = ADR_OFFSET + TX_OFS;
                m_wdata = tx_data;
                if (m_timeout) begin
                    state_next = S_DIS;
                end else if (m_ack) begin
                    state_next = abort_now ? S_DIS : S_STAT;
                end
            end
            S_RXR: begin
                m_req  = m_idle;
                m_addr = ADR_OFFSET + RX_OFS;
                if (m_timeout) begin
                    state_next = S_DIS;
                end else if (m_ack) begin
                    state_next = abort_now ? S_DIS : S_STAT;
                end
            end
            S_GAP: begin
                if (abort_now || all_done) begin
                    state_next = S_DIS;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_STAT;
                end
            end
            S_DIS: begin
                m_req   = m_idle;
                m_wr    = 1'b1;
                m_addr  = ADR_OFFSET + CTRL_OFS;
                m_wdata = with_tran_en(cfg_reg, 1'b0);
                if (m_timeout || m_ack) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg      <= S_IDLE;
            cfg_reg        <= '0;
            tx_len_reg     <= '0;
            rx_len_reg     <= '0;
            tx_sent_reg    <= '0;
            rx_got_reg     <= '0;
            last_tx_reg    <= 1'b0;
            abort_pend_reg <= 1'b0;
            gap_cnt_reg    <= '0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rx_valid_reg <= 1'b0;

            if (state_reg == S_IDLE) begin
                if (start) begin
                    cfg_reg        <= cfg;
                    tx_len_reg     <= tx_len;
                    rx_len_reg     <= rx_len;
                    tx_sent_reg    <= '0;
                    rx_got_reg     <= '0;
                    // Pretend TX was served last so the first tie goes to RX.
                    last_tx_reg    <= 1'b1;
                    abort_pend_reg <= 1'b0;
                end
            end else if (abort && (state_reg != S_DIS) && (state_reg != S_FIN)) begin
                abort_pend_reg <= 1'b1;
            end

            if ((state_reg == S_STAT) && m_ack && (pick_tx || pick_rx)) begin
                last_tx_reg <= pick_tx;
            end

            if ((state_reg == S_TXW) && m_ack && (tx_sent_reg < tx_len_reg)) begin
                tx_sent_reg <= tx_sent_reg + CNT_W'(1);
            end

            if ((state_reg == S_RXR) && m_ack) begin
                rx_data_reg  <= m_rdata;
                rx_valid_reg <= 1'b1;
                if (rx_got_reg < rx_len_reg) begin
                    rx_got_reg <= rx_got_reg + CNT_W'(1);
                end
            end

            if ((state_next == S_GAP) && (state_reg != S_GAP)) begin
                gap_cnt_reg <= '0;
            end else if (state_reg == S_GAP) begin
                gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
        end
    end

`ifdef I2S_SEQ_TIMEOUT_EN
    logic err_reg;

    always_ff @(posedge pclk) begin
        if (preset) begin
            err_reg <= 1'b0;
        end else if ((state_reg == S_IDLE) && start) begin
            err_reg <= 1'b0;
        end else if (m_timeout) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign busy     = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done     = (state_reg == S_FIN);
    assign tx_ready = (state_reg == S_TXW) && m_ack;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_i2s_apb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2s_apb_sequencer
// Directed stimulus against a behavioural APB slave. Each sequence pushes
// the expected APB completions, rx_valid words and done pulse into a queue;
// a forked monitor pops and compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_i2s_apb_sequencer;

    localparam logic [31:0] OFS  = 32'h10;
    localparam int          PG   = 4;
    localparam logic [31:0] CFGW = 32'hCAFE_0120;
    localparam logic [31:0] ENW  = 32'hCAFE_0121;

    logic        pclk = 1'b0;
    logic        preset, start, abort;
    logic [31:0] cfg;
    logic [15:0] tx_len, rx_len;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready;
    logic        busy, done, err;

    always #5 pclk = ~pclk;

    i2s_apb_sequencer #(
        .ADR_OFFSET (OFS),
        .CNT_W      (16),
        .POLL_GAP   (PG)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .start    (start),
        .abort    (abort),
        .cfg      (cfg),
        .tx_len   (tx_len),
        .rx_len   (rx_len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // ---------------- behavioural slave ----------------
    int          stall_tx   = 0;
    int          stall_all  = 0;
    int          full_until = 0;
    int          acc_cnt    = 0;
    int          stat_reads = 0;
    int          rx_idx     = 0;
    int          tx_idx     = 0;
    logic [31:0] rx_words [0:7];
    logic [31:0] tx_words [0:7];

    assign pready  = psel && penable &&
                     (acc_cnt >= ((paddr == OFS + 32'h4) ? stall_tx : stall_all));
    assign prdata  = (paddr == OFS + 32'h8) ? rx_words[rx_idx[2:0]] :
                     ((stat_reads < full_until) ? 32'h1 : 32'h0);
    assign tx_data = tx_words[tx_idx[2:0]];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && !pwrite) begin
            if (paddr == OFS + 32'hC) stat_reads <= stat_reads + 1;
            if (paddr == OFS + 32'h8) rx_idx <= rx_idx + 1;
        end
        if (tx_ready) tx_idx <= tx_idx + 1;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;   // 0 APB write, 1 APB read, 2 rx_valid, 3 done
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t     exp_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      n_txr = 0;
    longint  cyc   = 0;
    bit      rec_stat = 0;
    longint  stat_t[$];
    int      tx_base = 0;

    function automatic string kname(input int k);
        case (k)
            0:       return "WR";
            1:       return "RD";
            2:       return "RXV";
            default: return "DONE";
        endcase
    endfunction

    task automatic mon_step();
        ev_t got;
        ev_t e;
        bit  have;
        have = 0;
        got.kind = 0;
        got.addr = '0;
        got.data = '0;
        if (psel && penable && pready) begin
            got.kind = pwrite ? 0 : 1;
            got.addr = paddr;
            got.data = pwrite ? pwdata : prdata;
            have = 1;
            if (!pwrite && paddr == OFS + 32'hC && rec_stat) stat_t.push_back(cyc);
        end else if (rx_valid) begin
            got.kind = 2;
            got.data = rx_data;
            have = 1;
        end else if (done) begin
            got.kind = 3;
            have = 1;
        end
        if (tx_ready) n_txr++;
        if (have) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got %s addr=%h data=%h, required nothing", kname(got.kind), got.addr, got.data);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != got.kind || e.addr != got.addr || (e.kind != 1 && e.data != got.data)) begin
                    n_bad++;
                    $display("FAIL sb_event: got %s addr=%h data=%h, required %s addr=%h data=%h",
                             kname(got.kind), got.addr, got.data, kname(e.kind), e.addr, e.data);
                end else begin
                    $display("ok   sb_event: %s addr=%h data=%h", kname(got.kind), got.addr, got.data);
                end
            end
        end
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic start_seq(input logic [15:0] tl, input logic [15:0] rl);
        cfg    = CFGW;
        tx_len = tl;
        rx_len = rl;
        start  = 1'b1;
        @(negedge pclk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_timeout: got no done within %0d cycles, required done", nm, budget);
        end
        @(negedge pclk);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int  txr0;
        bit  hit;
        for (int i = 0; i < 8; i++) begin
            tx_words[i] = 32'h1111_1111 * (i + 1);
            rx_words[i] = 32'h0;
        end
        rx_words[0] = 32'h0000_A5A5;
        rx_words[1] = 32'h0000_5A5A;
        rx_words[2] = 32'h0BAD_F00D;
        rx_words[3] = 32'h1234_5678;
        preset = 1'b1; start = 1'b0; abort = 1'b0; tx_valid = 1'b0;
        cfg = '0; tx_len = '0; rx_len = '0;

        fork
            forever begin
                @(negedge pclk);
                cyc++;
                mon_step();
            end
        join_none

        repeat (3) @(negedge pclk);
        chk("rst_apb_ctl", {29'd0, psel, penable, pwrite}, 32'd0);
        preset = 1'b0;
        @(negedge pclk);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_flags", {27'd0, busy, done, tx_ready, rx_valid, err}, 32'd0);

        // T1: three TX words, no RX
        tx_valid = 1'b1;
        full_until = stat_reads;
        push(0, OFS, ENW);
        for (int i = 0; i < 3; i++) begin
            push(1, OFS + 32'hC, 0);
            push(0, OFS + 32'h4, tx_words[tx_base + i]);
        end
        tx_base += 3;
        push(0, OFS, CFGW);
        push(3, 0, 0);
        txr0 = n_txr;
        start_seq(16'd3, 16'd0);
        wait_done("t1_tx3", 300);
        chk("t1_tx_ready_count", n_txr - txr0, 3);

        // T2: two RX words
        tx_valid = 1'b0;
        push(0, OFS, ENW);
        push(1, OFS + 32'hC, 0); push(1, OFS + 32'h8, 0); push(2, 0, 32'h0000_A5A5);
        push(1, OFS + 32'hC, 0); push(1, OFS + 32'h8, 0); push(2, 0, 32'h0000_5A5A);
        push(0, OFS, CFGW);
        push(3, 0, 0);
        start_seq(16'd0, 16'd2);
        wait_done("t2_rx2", 300);

        // T3: both eligible every poll -> RX, TX, RX, TX
        tx_valid = 1'b1;
        push(0, OFS, ENW);
        push(1, OFS + 32'hC, 0); push(1, OFS + 32'h8, 0); push(2, 0, 32'h0BAD_F00D);
        push(1, OFS + 32'hC, 0); push(0, OFS + 32'h4, tx_words[tx_base]);
        push(1, OFS + 32'hC, 0); push(1, OFS + 32'h8, 0); push(2, 0, 32'h1234_5678);
        push(1, OFS + 32'hC, 0); push(0, OFS + 32'h4, tx_words[tx_base + 1]);
        tx_base += 2;
        push(0, OFS, CFGW);
        push(3, 0, 0);
        start_seq(16'd2, 16'd2);
        wait_done("t3_rr", 400);

        // T4: tx_full for 10 polls, gaps between polls
        full_until = stat_reads + 10;
        push(0, OFS, ENW);
        for (int i = 0; i < 11; i++) push(1, OFS + 32'hC, 0);
        push(0, OFS + 32'h4, tx_words[tx_base]);
        tx_base += 1;
        push(0, OFS, CFGW);
        push(3, 0, 0);
        stat_t.delete();
        rec_stat = 1;
        txr0 = n_txr;
        start_seq(16'd1, 16'd0);
        wait_done("t4_full", 600);
        rec_stat = 0;
        chk("t4_status_polls", stat_t.size(), 11);
        if (stat_t.size() == 11) begin
            for (int i = 1; i < 11; i++)
                chk($sformatf("t4_poll_spacing_%0d", i), 32'(stat_t[i] - stat_t[i-1]), PG + 3);
        end
        chk("t4_tx_ready_count", n_txr - txr0, 1);

        // T5: abort during a stalled TX write
        full_until = stat_reads;
        stall_tx = 5;
        push(0, OFS, ENW);
        push(1, OFS + 32'hC, 0);
        push(0, OFS + 32'h4, tx_words[tx_base]);
        tx_base += 1;
        push(0, OFS, CFGW);
        push(3, 0, 0);
        txr0 = n_txr;
        start_seq(16'd3, 16'd0);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (psel && penable && paddr == OFS + 32'h4) begin
                hit = 1;
                break;
            end
            @(negedge pclk);
        end
        chk("t5_tx_access_seen", {31'd0, hit}, 32'd1);
        abort = 1'b1;
        wait_done("t5_abort", 200);
        abort = 1'b0;
        stall_tx = 0;
        chk("t5_tx_ready_count", n_txr - txr0, 1);

        // T6: both lengths zero -> straight to disable write
        push(0, OFS, CFGW);
        push(3, 0, 0);
        start_seq(16'd0, 16'd0);
        wait_done("t6_zero", 100);

`ifdef I2S_SEQ_TIMEOUT_EN
        // T7: slave never ready -> both transfers time out
        stall_all = 100000;
        stall_tx  = 100000;
        push(3, 0, 0);
        start_seq(16'd1, 16'd0);
        wait_done("t7_timeout", 800);
        chk("t7_err", {31'd0, err}, 32'd1);
        chk("t7_psel", {31'd0, psel}, 32'd0);
        stall_all = 0;
        stall_tx  = 0;
`else
        chk("err_tied_low", {31'd0, err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
